// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared MIPS pipeline definitions: sequencer state encodings, register-zero
// constant, load-latency bounds and the per-stage control bundle.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

  localparam int REG_ZERO         = 0;
  localparam int LOAD_LATENCY_MIN = 1;
  localparam int LOAD_LATENCY_MAX = 7;
  localparam int BCNT_WIDTH       = 3;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctrl_t;

  // Bubble: hold PC and IF/ID, inject a NOP into ID/EX, let the back end drain.
  localparam stage_ctrl_t CTRL_OFF    = 7'b00000_00;
  localparam stage_ctrl_t CTRL_RUN    = 7'b11111_00;
  localparam stage_ctrl_t CTRL_STALL  = 7'b00111_01;
  localparam stage_ctrl_t CTRL_FREEZE = 7'b00000_00;
  localparam stage_ctrl_t CTRL_SQUASH = 7'b11111_11;

  function automatic int clamp_latency(input int lat);
    if (lat < LOAD_LATENCY_MIN) return LOAD_LATENCY_MIN;
    if (lat > LOAD_LATENCY_MAX) return LOAD_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Combinational load-use comparator between the load in EX and the
// source operands of the instruction in ID.
module load_use_detect
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_memRead_i,
  input  logic                      ex_writeReg_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
  input  logic                      id_usesRt_i,
  output logic                      lu_hit_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = REG_ADDR_WIDTH'(REG_ZERO);

  logic destValid;
  logic rsMatch;
  logic rtMatch;

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign destValid = ex_memRead_i & ex_writeReg_i & (ex_regToWrite_i != ZERO_REG);
  assign rsMatch   = (ex_regToWrite_i == id_rs_i);
  assign rtMatch   = id_usesRt_i & (ex_regToWrite_i == id_rt_i);
  assign lu_hit_o  = destValid & (rsMatch | rtMatch);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: load-use bubbles, data-memory wait freezes and
// taken-branch squashes, plus a saturating stall-cycle counter.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LATENCY   = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
  input  logic                      id_usesRt_i,
  input  logic                      ex_memRead_i,
  input  logic                      ex_writeReg_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite_i,
  input  logic                      ex_branchTaken_i,
  input  logic                      mem_busy_i,
  output logic                      pc_en_o,
  output logic                      ifid_en_o,
  output logic                      idex_en_o,
  output logic                      exmem_en_o,
  output logic                      memwb_en_o,
  output logic                      ifid_flush_o,
  output logic                      idex_flush_o,
  output logic [CNT_WIDTH-1:0]      stall_cycles_o
);

  localparam int                    LL_EFF       = clamp_latency(LOAD_LATENCY);
  localparam bit                    MULTI_BUBBLE = (LL_EFF > 1);
  localparam logic [BCNT_WIDTH-1:0] BCNT_INIT    =
    MULTI_BUBBLE ? BCNT_WIDTH'(LL_EFF - 2) : '0;

  hz_state_e              state_q, state_d;
  hz_state_e              savedState_q, savedState_d;
  hz_state_e              effState;
  logic [BCNT_WIDTH-1:0]  bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0]   stallCnt_q, stallCnt_d;
  logic                   luHit;
  stage_ctrl_t            ctrl;

  load_use_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_load_use_detect (
    .ex_memRead_i    (ex_memRead_i),
    .ex_writeReg_i   (ex_writeReg_i),
    .ex_regToWrite_i (ex_regToWrite_i),
    .id_rs_i         (id_rs_i),
    .id_rt_i         (id_rt_i),
    .id_usesRt_i     (id_usesRt_i),
    .lu_hit_o        (luHit)
  );

  // Once mem_busy drops the frozen cycles are over, so the cycle behaves as
  // the saved state immediately rather than spending an extra cycle in MEM_WAIT.
  assign effState = (state_q == ST_MEM_WAIT) ? savedState_q : state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      savedState_q <= ST_RUN;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      savedState_q <= savedState_d;
      bcnt_q       <= bcnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    savedState_d = savedState_q;
    bcnt_d       = bcnt_q;
    if (mem_busy_i) begin
      state_d      = ST_MEM_WAIT;
      savedState_d = effState;
    end else if (ex_branchTaken_i) begin
      state_d = ST_RUN;
      bcnt_d  = '0;
    end else begin
      unique case (effState)
        ST_LU_STALL: begin
          if (bcnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LU_STALL;
            bcnt_d  = BCNT_WIDTH'(bcnt_q - BCNT_WIDTH'(1));
          end
        end
        default: begin
          state_d = ST_RUN;
          if (luHit && MULTI_BUBBLE) begin
            state_d = ST_LU_STALL;
            bcnt_d  = BCNT_INIT;
          end
        end
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_ni) begin
      ctrl = CTRL_OFF;
    end else if (mem_busy_i) begin
      ctrl = CTRL_FREEZE;
    end else if (ex_branchTaken_i) begin
      ctrl = CTRL_SQUASH;
    end else if ((effState == ST_LU_STALL) || luHit) begin
      ctrl = CTRL_STALL;
    end
  end

  assign pc_en_o      = ctrl.pc_en;
  assign ifid_en_o    = ctrl.ifid_en;
  assign idex_en_o    = ctrl.idex_en;
  assign exmem_en_o   = ctrl.exmem_en;
  assign memwb_en_o   = ctrl.memwb_en;
  assign ifid_flush_o = ctrl.ifid_flush;
  assign idex_flush_o = ctrl.idex_flush;

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (!ctrl.pc_en && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cycles_o = stallCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: dut1 (LOAD_LATENCY=1, 4-bit counter) runs a vector table,
// dut3 (LOAD_LATENCY=3) runs the multi-cycle stall/freeze/branch sequences.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       memRead;
    logic       writeReg;
    logic [4:0] rd;
    logic       br;
    logic       busy;
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    logic [4:0] en;
    logic [1:0] fl;
  } vec_t;

  localparam logic [4:0] EN_RUN    = 5'b11111;
  localparam logic [4:0] EN_STALL  = 5'b00111;
  localparam logic [4:0] EN_FREEZE = 5'b00000;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  stim_t s1, s3;
  int nChecks = 0;
  int nFail = 0;

  logic pc1, ifid1, idex1, exmem1, memwb1, ifidFl1, idexFl1;
  logic pc3, ifid3, idex3, exmem3, memwb3, ifidFl3, idexFl3;
  logic [3:0]  stall1;
  logic [31:0] stall3;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(1), .CNT_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_ni(rstN),
    .id_rs_i(s1.rs), .id_rt_i(s1.rt), .id_usesRt_i(s1.usesRt),
    .ex_memRead_i(s1.memRead), .ex_writeReg_i(s1.writeReg), .ex_regToWrite_i(s1.rd),
    .ex_branchTaken_i(s1.br), .mem_busy_i(s1.busy),
    .pc_en_o(pc1), .ifid_en_o(ifid1), .idex_en_o(idex1), .exmem_en_o(exmem1),
    .memwb_en_o(memwb1), .ifid_flush_o(ifidFl1), .idex_flush_o(idexFl1),
    .stall_cycles_o(stall1)
  );

  pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .LOAD_LATENCY(3), .CNT_WIDTH(32)) dut3 (
    .clk_i(clk), .rst_ni(rstN),
    .id_rs_i(s3.rs), .id_rt_i(s3.rt), .id_usesRt_i(s3.usesRt),
    .ex_memRead_i(s3.memRead), .ex_writeReg_i(s3.writeReg), .ex_regToWrite_i(s3.rd),
    .ex_branchTaken_i(s3.br), .mem_busy_i(s3.busy),
    .pc_en_o(pc3), .ifid_en_o(ifid3), .idex_en_o(idex3), .exmem_en_o(exmem3),
    .memwb_en_o(memwb3), .ifid_flush_o(ifidFl3), .idex_flush_o(idexFl3),
    .stall_cycles_o(stall3)
  );

  function automatic stim_t st(input int rs, input int rt, input bit ut, input bit mr,
                               input bit wr, input int rd, input bit br, input bit busy);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.usesRt = ut; s.memRead = mr;
    s.writeReg = wr; s.rd = 5'(rd); s.br = br; s.busy = busy;
    return s;
  endfunction

  function automatic vec_t mkv(input string name, input stim_t s,
                               input logic [4:0] en, input logic [1:0] fl);
    vec_t v;
    v.name = name; v.s = s; v.en = en; v.fl = fl;
    return v;
  endfunction

  task automatic applyStimulus(input stim_t a, input stim_t b);
    @(negedge clk);
    s1 = a;
    s3 = b;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCtrl1(input string name, input logic [4:0] en, input logic [1:0] fl);
    checkOutput({name, " en"}, 32'({pc1, ifid1, idex1, exmem1, memwb1}), 32'(en));
    checkOutput({name, " flush"}, 32'({ifidFl1, idexFl1}), 32'(fl));
  endtask

  task automatic checkCtrl3(input string name, input logic [4:0] en, input logic [1:0] fl);
    checkOutput({name, " en"}, 32'({pc3, ifid3, idex3, exmem3, memwb3}), 32'(en));
    checkOutput({name, " flush"}, 32'({ifidFl3, idexFl3}), 32'(fl));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[14];
    stim_t idle, ld7, ld7b, ld9, ld9br, ld4;
    int expStall;

    idle  = st(1, 2, 1, 0, 0, 0, 0, 0);
    ld7   = st(7, 2, 1, 1, 1, 7, 0, 0);
    ld7b  = st(7, 2, 1, 1, 1, 7, 0, 1);
    ld9   = st(9, 3, 1, 1, 1, 9, 0, 0);
    ld9br = st(9, 3, 1, 1, 1, 9, 1, 0);
    ld4   = st(4, 4, 1, 1, 1, 4, 0, 0);

    tbl[0]  = mkv("idle",            idle,                          EN_RUN,    2'b00);
    tbl[1]  = mkv("lu rs",           st(5, 2, 1, 1, 1, 5, 0, 0),    EN_STALL,  2'b01);
    tbl[2]  = mkv("lu rt",           st(3, 5, 1, 1, 1, 5, 0, 0),    EN_STALL,  2'b01);
    tbl[3]  = mkv("rt unused",       st(3, 5, 0, 1, 1, 5, 0, 0),    EN_RUN,    2'b00);
    tbl[4]  = mkv("load r0",         st(0, 0, 1, 1, 1, 0, 0, 0),    EN_RUN,    2'b00);
    tbl[5]  = mkv("no writeReg",     st(5, 2, 1, 1, 0, 5, 0, 0),    EN_RUN,    2'b00);
    tbl[6]  = mkv("alu producer",    st(5, 2, 1, 0, 1, 5, 0, 0),    EN_RUN,    2'b00);
    tbl[7]  = mkv("branch+lu",       st(5, 2, 1, 1, 1, 5, 1, 0),    EN_RUN,    2'b11);
    tbl[8]  = mkv("branch",          st(1, 2, 1, 0, 0, 0, 1, 0),    EN_RUN,    2'b11);
    tbl[9]  = mkv("busy",            st(1, 2, 1, 0, 0, 0, 0, 1),    EN_FREEZE, 2'b00);
    tbl[10] = mkv("busy+br+lu",      st(5, 2, 1, 1, 1, 5, 1, 1),    EN_FREEZE, 2'b00);
    tbl[11] = mkv("deferred branch", st(1, 2, 1, 0, 0, 0, 1, 0),    EN_RUN,    2'b11);
    tbl[12] = mkv("lu r31",          st(31, 2, 1, 1, 1, 31, 0, 0),  EN_STALL,  2'b01);
    tbl[13] = mkv("other dest",      st(5, 5, 1, 1, 1, 6, 0, 0),    EN_RUN,    2'b00);

    s1 = idle;
    s3 = idle;
    $display("[TB] reset phase");
    #12;
    checkCtrl1("reset dut1", EN_FREEZE, 2'b00);
    checkCtrl3("reset dut3", EN_FREEZE, 2'b00);
    checkOutput("reset stall1", 32'(stall1), 32'd0);
    checkOutput("reset stall3", stall3, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkCtrl1("post-reset dut1", EN_RUN, 2'b00);

    $display("[TB] vector table on dut1");
    expStall = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].s, idle);
      checkCtrl1(tbl[i].name, tbl[i].en, tbl[i].fl);
      if (tbl[i].en[4] == 1'b0) expStall++;
    end
    applyStimulus(idle, idle);
    checkOutput("table stall1", 32'(stall1), 32'(expStall));
    checkOutput("idle stall3", stall3, 32'd0);

    $display("[TB] dut3 load-use with memory wait");
    applyStimulus(idle, ld7);  checkCtrl3("ll3 c0", EN_STALL,  2'b01);
    applyStimulus(idle, ld7b); checkCtrl3("ll3 c1", EN_FREEZE, 2'b00);
    applyStimulus(idle, ld7b); checkCtrl3("ll3 c2", EN_FREEZE, 2'b00);
    applyStimulus(idle, ld7);  checkCtrl3("ll3 c3", EN_STALL,  2'b01);
    applyStimulus(idle, ld7);  checkCtrl3("ll3 c4", EN_STALL,  2'b01);
    applyStimulus(idle, idle); checkCtrl3("ll3 c5", EN_RUN,    2'b00);
    checkOutput("ll3 stall count", stall3, 32'd5);

    $display("[TB] dut3 branch abandons stall");
    applyStimulus(idle, ld9);   checkCtrl3("abandon c0", EN_STALL, 2'b01);
    applyStimulus(idle, ld9br); checkCtrl3("abandon c1", EN_RUN,   2'b11);
    applyStimulus(idle, idle);  checkCtrl3("abandon c2", EN_RUN,   2'b00);
    checkOutput("abandon stall count", stall3, 32'd6);

    $display("[TB] dut3 back-to-back load-use");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(idle, ld4);
      checkCtrl3($sformatf("b2b c%0d", i), EN_STALL, 2'b01);
    end
    applyStimulus(idle, idle);
    checkCtrl3("b2b done", EN_RUN, 2'b00);
    checkOutput("b2b stall count", stall3, 32'd12);

    $display("[TB] reset during stall");
    applyStimulus(idle, ld4);
    checkCtrl3("pre-reset stall", EN_STALL, 2'b01);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkCtrl3("mid-stall reset", EN_FREEZE, 2'b00);
    checkOutput("mid-stall reset stall3", stall3, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    s3 = idle;
    #1;
    checkCtrl3("release c0", EN_RUN, 2'b00);
    applyStimulus(idle, idle);
    checkCtrl3("release c1", EN_RUN, 2'b00);
    checkOutput("release stall3", stall3, 32'd0);
    checkOutput("release stall1", 32'(stall1), 32'd0);

    $display("[TB] dut1 counter saturation");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(st(1, 2, 1, 0, 0, 0, 0, 1), idle);
      if (i == 0) checkCtrl1("sat freeze", EN_FREEZE, 2'b00);
      if (i == 14) checkOutput("sat count 14", 32'(stall1), 32'd14);
    end
    applyStimulus(idle, idle);
    checkOutput("sat count 15", 32'(stall1), 32'd15);
    checkCtrl1("sat release", EN_RUN, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
